multicycle_controller: RTL and testbench

- Multi-cycle control FSM that sequences the processor datapath around the instruction decoder: fetches an instruction, holds it stable for decode, then drives ALU, data-memory and register-file write strobes across FETCH/DECODE/EXEC/MEM/WB.
- Owns the PC and the instruction/data memory request handshakes.
- Supports LD (opcode 0000011, funct3 011), SD (0100011, funct3 011), ADD (0110011/000/funct7 0000000) and SUB (0110011/000/funct7 0100000).
- Any other encoding halts the core.

---
 rtl/multicycle_controller.sv | 155 +++++++++++++++
 tb/tb_multicycle_controller.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: fetch, decode, execute, memory and writeback sequencing
// for a small LD/SD/ADD/SUB core. Owns the PC and both memory request handshakes.
module multicycle_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_valid,
    input  logic [31:0] inst_rdata,
    output logic [31:0] inst,
    output logic        alu_ctrl,
    output logic        data_req,
    output logic        data_we,
    input  logic        data_ready,
    output logic        reg_write_enable,
    output logic        reg_write_sel,
    output logic [31:0] pc,
    output logic        retired,
    output logic        illegal,
    output logic        bus_error
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        C_LD,
        C_SD,
        C_ADD,
        C_SUB
    } iclass_t;

    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

    state_t  state, state_nx;
    iclass_t iclass;
    iclass_t dec_class;
    logic    dec_legal;
    logic [3:0] wait_cnt;
    logic    timeout_hit;

    assign timeout_hit = (wait_cnt == TIMEOUT_CNT);

    // LD/SD are identified by opcode and funct3 alone; their upper bits are immediate.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dec_legal = 1'b0;
        dec_class = C_ADD;
        if (inst[14:12] == 3'b011 && inst[6:0] == 7'b0000011) begin
            dec_legal = 1'b1;
            dec_class = C_LD;
        end else if (inst[14:12] == 3'b011 && inst[6:0] == 7'b0100011) begin
            dec_legal = 1'b1;
            dec_class = C_SD;
        end else if (inst[14:12] == 3'b000 && inst[6:0] == 7'b0110011) begin
            if (inst[31:25] == 7'b0000000) begin
                dec_legal = 1'b1;
                dec_class = C_ADD;
            end else if (inst[31:25] == 7'b0100000) begin
                dec_legal = 1'b1;
                dec_class = C_SUB;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH: begin
                if (inst_valid)       state_nx = S_DECODE;
                else if (timeout_hit) state_nx = S_HALT;
            end
            S_DECODE: state_nx = dec_legal ? S_EXEC : S_HALT;
            S_EXEC:   state_nx = (iclass == C_LD || iclass == C_SD) ? S_MEM : S_WB;
            S_MEM: begin
                if (data_ready)       state_nx = S_WB;
                else if (timeout_hit) state_nx = S_HALT;
            end
            S_WB:     state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= S_FETCH;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            inst      <= '0;
            wait_cnt  <= '0;
            iclass    <= C_ADD;
            alu_ctrl  <= 1'b0;
            illegal   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (inst_valid) begin
                        inst     <= inst_rdata;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        bus_error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        iclass   <= dec_class;
                        alu_ctrl <= (dec_class == C_SUB);
                    end else begin
                        illegal <= 1'b1;
                    end
                end
                // The data phase starts its timeout from zero.
                S_EXEC: wait_cnt <= '0;
                S_MEM: begin
                    if (data_ready) begin
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        bus_error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_WB:    pc <= pc + 32'd4;
                default: ;
            endcase
        end
    end

    // All strobes decode from registered state only; no input reaches an output combinationally.
    assign inst_req         = (state == S_FETCH);
    assign inst_addr        = pc;
    assign data_req         = (state == S_MEM);
    assign data_we          = (state == S_MEM) && (iclass == C_SD);
    assign reg_write_enable = (state == S_WB) && (iclass != C_SD);
    assign reg_write_sel    = (state == S_WB) && (iclass == C_LD);
    assign retired          = (state == S_WB);

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: the stimulus side predicts each
// retire/halt event from the instruction rules, a monitor compares what the DUT presents.
module tb_multicycle_controller;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req, inst_valid = 1'b0;
    logic [31:0] inst_addr, inst_rdata = '0, inst, pc;
    logic        alu_ctrl, data_req, data_we, data_ready = 1'b0;
    logic        reg_write_enable, reg_write_sel, retired, illegal, bus_error;

    logic        w_reset = 1'b1, w_inst_req, w_inst_valid = 1'b0;
    logic [31:0] w_inst_addr, w_inst_rdata = '0, w_inst, w_pc;
    logic        w_alu_ctrl, w_data_req, w_data_we, w_data_ready = 1'b0;
    logic        w_reg_write_enable, w_reg_write_sel, w_retired, w_illegal, w_bus_error;

    always #5 clk = ~clk;

    multicycle_controller #(.RESET_PC(RPC), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_valid(inst_valid),
        .inst_rdata(inst_rdata), .inst(inst), .alu_ctrl(alu_ctrl),
        .data_req(data_req), .data_we(data_we), .data_ready(data_ready),
        .reg_write_enable(reg_write_enable), .reg_write_sel(reg_write_sel),
        .pc(pc), .retired(retired), .illegal(illegal), .bus_error(bus_error)
    );

    multicycle_controller #(.RESET_PC(WRAP_PC), .TIMEOUT(15)) u_wrap (
        .clk(clk), .reset(w_reset),
        .inst_req(w_inst_req), .inst_addr(w_inst_addr), .inst_valid(w_inst_valid),
        .inst_rdata(w_inst_rdata), .inst(w_inst), .alu_ctrl(w_alu_ctrl),
        .data_req(w_data_req), .data_we(w_data_we), .data_ready(w_data_ready),
        .reg_write_enable(w_reg_write_enable), .reg_write_sel(w_reg_write_sel),
        .pc(w_pc), .retired(w_retired), .illegal(w_illegal), .bus_error(w_bus_error)
    );

    // kind: 0 = retire, 1 = illegal halt, 2 = bus error halt
    typedef struct {
        int          kind;
        logic [31:0] pc;
        logic [31:0] word;
        logic        we;
        logic        sel;
        logic        alu;
        logic        dwe;
        int          lat;
        int          dreq;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_pc;
    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Class from the instruction-set rules: 0 LD, 1 SD, 2 ADD, 3 SUB, -1 illegal.
    function automatic int classify(input logic [31:0] w);
        if (w[6:0] == 7'b0000011 && w[14:12] == 3'b011) return 0;
        if (w[6:0] == 7'b0100011 && w[14:12] == 3'b011) return 1;
        if (w[6:0] == 7'b0110011 && w[14:12] == 3'b000 && w[31:25] == 7'b0000000) return 2;
        if (w[6:0] == 7'b0110011 && w[14:12] == 3'b000 && w[31:25] == 7'b0100000) return 3;
        return -1;
    endfunction

    function automatic logic [31:0] gen_word(input int k);
        logic [31:0] r;
        r = $urandom;
        case (k)
            0: begin r[14:12] = 3'b011; r[6:0] = 7'b0000011; end
            1: begin r[14:12] = 3'b011; r[6:0] = 7'b0100011; end
            2: begin r[31:25] = 7'b0000000; r[14:12] = 3'b000; r[6:0] = 7'b0110011; end
            default: begin r[31:25] = 7'b0100000; r[14:12] = 3'b000; r[6:0] = 7'b0110011; end
        endcase
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        inst_valid = 1'b0;
        data_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_pc = RPC;
    endtask

    task automatic check_reset_state();
        check("rst_inst_req", inst_req, 1);
        check("rst_pc", pc, RPC);
        check("rst_inst_addr", inst_addr, RPC);
        check("rst_inst", inst, 0);
        check("rst_strobes", {data_req, data_we, reg_write_enable, reg_write_sel, retired}, 0);
        check("rst_alu_ctrl", alu_ctrl, 0);
        check("rst_sticky", {illegal, bus_error}, 0);
    endtask

    // inst_valid/data_ready noise while the DUT is outside the phase that listens to them.
    task automatic wait_req();
        int n = 0;
        while (inst_req !== 1'b1 && n < 100) begin
            inst_valid = 1'($urandom);
            data_ready = 1'($urandom);
            inst_rdata = $urandom;
            @(negedge clk);
            n++;
        end
        check("fetch_req_seen", inst_req, 1);
    endtask

    task automatic wait_data();
        int n = 0;
        data_ready = 1'b0;
        while (data_req !== 1'b1 && n < 100) begin
            inst_valid = 1'($urandom);
            @(negedge clk);
            n++;
        end
        check("data_req_seen", data_req, 1);
    endtask

    task automatic present_inst(input logic [31:0] word, input int fw);
        repeat (fw) begin
            inst_valid = 1'b0;
            inst_rdata = $urandom;
            data_ready = 1'($urandom);
            @(negedge clk);
        end
        inst_valid = 1'b1;
        inst_rdata = word;
        data_ready = 1'b0;
        @(negedge clk);
        inst_valid = 1'b0;
        inst_rdata = $urandom;
    endtask

    task automatic issue(input logic [31:0] word, input int fw, input int dw);
        exp_t e;
        int   k;
        bit   mem;
        k = classify(word);
        mem = (k == 0 || k == 1);
        e.kind = (k < 0) ? 1 : 0;
        e.pc   = model_pc;
        e.word = word;
        e.we   = (k == 0 || k == 2 || k == 3);
        e.sel  = (k == 0);
        e.alu  = (k == 3);
        e.dwe  = (k == 1);
        e.dreq = mem ? 1 + dw : 0;
        e.lat  = (k < 0) ? 3 + fw : 4 + fw + (mem ? 1 + dw : 0);
        sb.push_back(e);
        if (k >= 0) model_pc = model_pc + 32'd4;
        wait_req();
        present_inst(word, fw);
        if (mem) begin
            wait_data();
            repeat (dw) begin
                inst_valid = 1'($urandom);
                @(negedge clk);
            end
            data_ready = 1'b1;
            @(negedge clk);
            data_ready = 1'b0;
            inst_valid = 1'b0;
        end
    endtask

    task automatic fetch_timeout();
        exp_t e;
        e = '{kind: 2, pc: model_pc, word: 0, we: 0, sel: 0, alu: 0, dwe: 0, lat: 17, dreq: 0};
        sb.push_back(e);
        wait_req();
        repeat (24) begin
            inst_valid = 1'b0;
            data_ready = 1'($urandom);
            @(negedge clk);
        end
        check("fetch_to_halted", bus_error, 1);
    endtask

    task automatic data_timeout();
        exp_t e;
        e = '{kind: 2, pc: model_pc, word: 0, we: 0, sel: 0, alu: 0, dwe: 0, lat: 20, dreq: 0};
        sb.push_back(e);
        wait_req();
        present_inst(32'h0000B083, 0);
        wait_data();
        repeat (22) begin
            data_ready = 1'b0;
            inst_valid = 1'($urandom);
            @(negedge clk);
        end
        inst_valid = 1'b0;
        check("data_to_halted", bus_error, 1);
    endtask

    // Monitor: tracks fetch start and data-phase activity, compares each event with the queue head.
    initial begin : monitor
        logic prev_req = 1'b0, prev_ill = 1'b0, prev_be = 1'b0;
        int   start = 0, dcnt = 0, ev;
        logic dwe_seen = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (inst_req === 1'b1 && prev_req !== 1'b1) begin
                start = cycle;
                dcnt = 0;
                dwe_seen = 1'b0;
            end
            prev_req = inst_req;
            if (data_req === 1'b1) begin
                dcnt++;
                dwe_seen = dwe_seen | data_we;
            end
            if (illegal === 1'b1 || bus_error === 1'b1)
                check("halt_strobes", {inst_req, data_req, retired, reg_write_enable}, 0);
            ev = -1;
            if (retired === 1'b1)                          ev = 0;
            else if (illegal === 1'b1 && prev_ill !== 1'b1) ev = 1;
            else if (bus_error === 1'b1 && prev_be !== 1'b1) ev = 2;
            prev_ill = illegal;
            prev_be = bus_error;
            if (ev >= 0) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event kind=%0d with empty scoreboard (t=%0t)", ev, $time);
                end else begin
                    e = sb.pop_front();
                    check("event_kind", ev, e.kind);
                    check("event_pc", pc, e.pc);
                    check("event_latency", cycle - start + 1, e.lat);
                    if (ev == 0) begin
                        check("wb_reg_we", reg_write_enable, e.we);
                        check("wb_reg_sel", reg_write_sel, e.sel);
                        check("wb_alu_ctrl", alu_ctrl, e.alu);
                        check("wb_inst", inst, e.word);
                        check("data_req_cycles", dcnt, e.dreq);
                        check("data_we", dwe_seen, e.dwe);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        do_reset();
        check_reset_state();

        issue(32'h003100B3, 0, 0);
        issue(32'h403100B3, 0, 0);
        issue(32'h0000B083, 0, 2);
        issue(32'h0010B023, 0, 0);
        for (int i = 0; i < 40; i++)
            issue(gen_word($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3));

        issue(32'h00000013, 0, 0);
        repeat (8) @(negedge clk);
        check("illegal_sticky", illegal, 1);
        check("illegal_pc_held", pc, model_pc);
        do_reset();
        check_reset_state();
        issue(32'h003100B3, 1, 0);

        fetch_timeout();
        do_reset();
        check_reset_state();
        data_timeout();
        do_reset();
        check_reset_state();

        // Reset in the middle of a data-phase wait abandons the load with no writeback.
        wait_req();
        present_inst(32'h0000B083, 0);
        wait_data();
        @(negedge clk);
        do_reset();
        check_reset_state();
        issue(32'h403100B3, 0, 0);

        // PC wrap on the second instance, which resets to the last word of the address space.
        w_reset = 1'b0;
        w_inst_valid = 1'b1;
        w_inst_rdata = 32'h003100B3;
        check("wrap_start_pc", w_pc, WRAP_PC);
        @(negedge clk);
        w_inst_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("wrap_retired", w_retired, 1);
        check("wrap_wb_pc", w_pc, WRAP_PC);
        @(negedge clk);
        check("wrap_pc", w_pc, 0);
        check("wrap_refetch", w_inst_req, 1);
        w_reset = 1'b1;

        repeat (6) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
